// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the sliced pipelined adder.
package pipelined_adder_pkg;

  // Number of pipeline stages for a given operand width and slice width.
  function automatic int unsigned stage_count(input int unsigned width, input int unsigned slice);
    return (slice == 0) ? 1 : width / slice;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into its MSB.
module adder_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SLICE:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = carry[SLICE];
  assign c_msb_in = carry[SLICE-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: one SLICE-bit slice resolved per stage, carry registered between
// stages, whole pipeline stalls together when the output is held.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow
);

  localparam int unsigned STAGES = stage_count(WIDTH, SLICE);

  if (SLICE == 0 || (WIDTH % SLICE) != 0) begin : g_bad_param
    $error("pipelined_adder: WIDTH must be a non-zero multiple of SLICE");
  end

  logic             advance;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  assign advance  = !out_valid || out_ready;
  assign in_ready = rst || advance;
  // Subtraction is A + ~B + ~borrow, so the carry out reads as "no borrow".
  assign b_in     = sub ? ~operand2 : operand2;
  assign c_in     = sub ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Done = (k + 1) * SLICE;
    localparam int unsigned Todo = WIDTH - k * SLICE;

    logic [Todo-1:0]  a_src, b_src;
    logic             c_src, v_src;
    logic [SLICE-1:0] s;
    logic             co, c_msb;
    logic [Done-1:0]  res_d, res_q;
    logic             valid_q, carry_q;

    if (k == 0) begin : g_first
      assign a_src = operand1;
      assign b_src = b_in;
      assign c_src = c_in;
      assign v_src = in_valid;
      assign res_d = s;
    end else begin : g_next
      assign a_src = g_stage[k-1].g_fwd.a_q;
      assign b_src = g_stage[k-1].g_fwd.b_q;
      assign c_src = g_stage[k-1].carry_q;
      assign v_src = g_stage[k-1].valid_q;
      assign res_d = {s, g_stage[k-1].res_q};
    end

    adder_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .a       (a_src[SLICE-1:0]),
      .b       (b_src[SLICE-1:0]),
      .cin     (c_src),
      .sum     (s),
      .cout    (co),
      .c_msb_in(c_msb)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (advance) begin
        valid_q <= v_src;
        carry_q <= co;
        res_q   <= res_d;
      end
    end

    // Only the operand bits not yet added travel on to later stages.
    if (k < STAGES - 1) begin : g_fwd
      logic [Todo-SLICE-1:0] a_q, b_q;
      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= a_src[Todo-1:SLICE];
          b_q <= b_src[Todo-1:SLICE];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= c_msb ^ co;
        end
      end
    end else begin : g_mid
      logic unused_msb;
      assign unused_msb = c_msb;
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign Result    = g_stage[STAGES-1].res_q;
  assign Cout      = g_stage[STAGES-1].carry_q;
  assign Overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: default 32/8 instance plus 16/16, 16/4 and 64/8 instances.
module tb_pipelined_adder;

  localparam int unsigned STAGES = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, cin, sub, out_ready;
  logic [31:0] operand1, operand2, result;
  logic        in_ready, out_valid, cout, overflow;

  logic        sw_valid, sw_cin, sw_sub, sw_out_ready;
  logic [15:0] a16a, b16a, a16b, b16b, r16a, r16b;
  logic [63:0] a64, b64, r64;
  logic        ir16a, ir16b, ir64, v16a, v16b, v64, c16a, c16b, c64, o16a, o16b, o64;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_adder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(result), .Cout(cout), .Overflow(overflow)
  );

  pipelined_adder #(.WIDTH(16), .SLICE(16)) u_w16s16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(ir16a),
    .operand1(a16a), .operand2(b16a), .cin(sw_cin), .sub(sw_sub),
    .out_valid(v16a), .out_ready(sw_out_ready),
    .Result(r16a), .Cout(c16a), .Overflow(o16a)
  );

  pipelined_adder #(.WIDTH(16), .SLICE(4)) u_w16s4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(ir16b),
    .operand1(a16b), .operand2(b16b), .cin(sw_cin), .sub(sw_sub),
    .out_valid(v16b), .out_ready(sw_out_ready),
    .Result(r16b), .Cout(c16b), .Overflow(o16b)
  );

  pipelined_adder #(.WIDTH(64), .SLICE(8)) u_w64s8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(ir64),
    .operand1(a64), .operand2(b64), .cin(sw_cin), .sub(sw_sub),
    .out_valid(v64), .out_ready(sw_out_ready),
    .Result(r64), .Cout(c64), .Overflow(o64)
  );

  // Reference: {overflow, cout, result} of A+B+cin or A-B-cin.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic s);
    logic [32:0] wide;
    logic [31:0] r;
    logic        co, ov;
    if (s) begin
      r  = a - b - {31'b0, c};
      co = ({1'b0, a} >= ({1'b0, b} + {32'b0, c}));
      ov = (a[31] != b[31]) && (r[31] != a[31]);
    end else begin
      wide = {1'b0, a} + {1'b0, b} + {32'b0, c};
      r    = wide[31:0];
      co   = wide[32];
      ov   = (a[31] == b[31]) && (r[31] != a[31]);
    end
    return {ov, co, r};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sw_valid = 1'b0; sw_out_ready = 1'b1;
    operand1 = '0; operand2 = '0; cin = 1'b0; sub = 1'b0;
    a16a = '0; b16a = '0; a16b = '0; b16b = '0; a64 = '0; b64 = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, cout, overflow, result} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b cout=%b ovf=%b res=%h, want all 0",
               out_valid, cout, overflow, result);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_during: got %b want 1", in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[6], tb_[6], tr[6];
    logic        tc[6], ts[6], tco[6], tov[6];
    int          lat;
    ta  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_000A, 32'h0000_00FF};
    tb_ = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001, 32'h0000_0003, 32'h0000_0000};
    tc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ts  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tr  = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0000_0006, 32'h0000_0100};
    tco = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tov = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      operand1 = ta[i]; operand2 = tb_[i]; cin = tc[i]; sub = ts[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != STAGES) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, STAGES);
      end
      checks++;
      if (result !== tr[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, result, tr[i]);
      end
      checks++;
      if (cout !== tco[i] || overflow !== tov[i]) begin
        errors++;
        $display("FAIL directed_flags[%0d]: got cout=%b ovf=%b want %b/%b",
                 i, cout, overflow, tco[i], tov[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 100;
    logic [33:0] e;
    int          got;
    logic        want_v;
    got = 0;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < N + STAGES + 2; i++) begin
      @(negedge clk);
      want_v = (i >= STAGES) && (i < N + STAGES);
      checks++;
      if (out_valid !== want_v) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: got %b want %b", i, out_valid, want_v);
      end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra[%0d]: got res=%h want no result", i, result);
        end else begin
          e = exp_q.pop_front();
          got++;
          if ({overflow, cout, result} !== e) begin
            errors++;
            $display("FAIL b2b_data[%0d]: got ovf=%b cout=%b res=%h want ovf=%b cout=%b res=%h",
                     i, overflow, cout, result, e[33], e[32], e[31:0]);
          end
        end
      end
      if (i < N) begin
        operand1 = $urandom; operand2 = $urandom;
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) exp_q.push_back(model(operand1, operand2, cin, sub));
    end
    checks++;
    if (got != N) begin
      errors++;
      $display("FAIL b2b_count: got %0d want %0d", got, N);
    end
  endtask

  task automatic test_stall();
    logic [33:0] held, e;
    logic        held_v;
    int          j, got;
    held_v = 1'b0; held = '0; j = 0; got = 0;
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (held_v) begin
          checks++;
          if ({overflow, cout, result} !== held) begin
            errors++;
            $display("FAIL stall_stable[%0d]: got %h want %h", i, {overflow, cout, result}, held);
          end
        end else begin
          held   = {overflow, cout, result};
          held_v = 1'b1;
        end
      end
      checks++;
      if (in_ready !== !out_valid) begin
        errors++;
        $display("FAIL stall_in_ready[%0d]: got %b want %b", i, in_ready, !out_valid);
      end
      operand1 = 32'h1111_1111 * (j + 1); operand2 = 32'h0F0F_0F0F;
      cin = j[0]; sub = j[1]; in_valid = 1'b1;
      #1;
      if (in_ready) begin
        exp_q.push_back(model(operand1, operand2, cin, sub));
        j++;
      end
    end
    checks++;
    if (j != STAGES) begin
      errors++;
      $display("FAIL stall_accepted: got %0d want %0d", j, STAGES);
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      else @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stall_dup[%0d]: got res=%h want no result", k, result);
        end else begin
          e = exp_q.pop_front();
          got++;
          if ({overflow, cout, result} !== e) begin
            errors++;
            $display("FAIL stall_drain[%0d]: got %h want %h", k, {overflow, cout, result}, e);
          end
        end
      end
    end
    checks++;
    if (got != STAGES) begin
      errors++;
      $display("FAIL stall_drain_count: got %0d want %0d", got, STAGES);
    end
  endtask

  task automatic test_reset_flush();
    int seen, lat;
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      operand1 = 32'hA000_0000 + i; operand2 = 32'h0000_0100; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_next: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_ghosts: got %0d results want 0", seen);
    end
    @(negedge clk);
    operand1 = 32'h1234_5678; operand2 = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != STAGES || result !== 32'h2345_6789) begin
      errors++;
      $display("FAIL flush_after: got lat=%0d res=%h want lat=%0d res=23456789",
               lat, result, STAGES);
    end
  endtask

  task automatic test_sweep();
    int          la, lb, lc;
    logic [15:0] ra, rb;
    logic [63:0] rc;
    logic [1:0]  fa, fb, fc;
    la = 0; lb = 0; lc = 0; ra = '0; rb = '0; rc = '0; fa = '0; fb = '0; fc = '0;
    @(negedge clk);
    a16a = 16'hFFFF; b16a = 16'h0001;
    a16b = 16'h7FFF; b16b = 16'h0001;
    a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'h1;
    sw_cin = 1'b0; sw_sub = 1'b0; sw_out_ready = 1'b1; sw_valid = 1'b1;
    @(negedge clk);
    sw_valid = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      if (v16a && la == 0) begin la = t; ra = r16a; fa = {c16a, o16a}; end
      if (v16b && lb == 0) begin lb = t; rb = r16b; fb = {c16b, o16b}; end
      if (v64 && lc == 0) begin lc = t; rc = r64; fc = {c64, o64}; end
      @(negedge clk);
    end
    checks++;
    if (la != 1 || ra !== 16'h0000 || fa !== 2'b10) begin
      errors++;
      $display("FAIL sweep_16_16: got lat=%0d res=%h co/ov=%b want 1 0000 10", la, ra, fa);
    end
    checks++;
    if (lb != 4 || rb !== 16'h8000 || fb !== 2'b01) begin
      errors++;
      $display("FAIL sweep_16_4: got lat=%0d res=%h co/ov=%b want 4 8000 01", lb, rb, fb);
    end
    checks++;
    if (lc != 8 || rc !== 64'h0 || fc !== 2'b10) begin
      errors++;
      $display("FAIL sweep_64_8: got lat=%0d res=%h co/ov=%b want 8 0 10", lc, rc, fc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
